// File: rtl/rr_mux_8to1.sv
// Round-robin 8:1 collector: registers one requesting channel's word as D with its index S; a load edge produces valid and a one-cycle grant one clock later.
// Backpressure: D/S/valid hold while ready=0 and req is ignored; a word accepted with ready=1 can be replaced on the same edge, so there is no idle bubble.
module rr_mux_8to1 #(
    parameter int DATA_W = 1,
    parameter int NCH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        req,
    input  logic [NCH*DATA_W-1:0] din,
    input  logic                  ready,
    output logic [DATA_W-1:0]     D,
    output logic [2:0]            S,
    output logic                  valid,
    output logic [NCH-1:0]        grant,
    output logic                  busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [DATA_W-1:0]   d_q, d_d;
    logic [2:0]          s_q, s_d;
    logic [NCH-1:0]      grant_q, grant_d;
    logic [2:0]          sel;
    logic [2:0]          idx;
    logic                found;
    logic                load;

    // Scan starts at ptr and wraps mod 8, so the last-served channel is checked last.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = ptr_q + 3'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign load = (state_q == IDLE) || ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        d_d     = d_q;
        s_d     = s_q;
        grant_d = '0;
        if (load) begin
            if (found) begin
                d_d          = din[int'(sel)*DATA_W +: DATA_W];
                s_d          = sel;
                ptr_d        = sel + 3'd1;
                state_d      = HOLD;
                grant_d[sel] = 1'b1;
            end else begin
                // Accepted with nothing queued: D and S keep their last values.
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            d_q     <= '0;
            s_q     <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            d_q     <= d_d;
            s_q     <= s_d;
            grant_q <= grant_d;
        end
    end

    assign D     = d_q;
    assign S     = s_q;
    assign valid = (state_q == HOLD);
    assign grant = grant_q;
    assign busy  = (state_q == HOLD) | (|req);

endmodule

// File: tb/tb_rr_mux_8to1.sv
// Bench for rr_mux_8to1: behavioural round-robin model compared every cycle, plus directed literal expectations.
module tb_rr_mux_8to1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] din;
    logic       ready;
    logic       D;
    logic [2:0] S;
    logic       valid;
    logic [7:0] grant;
    logic       busy;

    always #5 clk = ~clk;

    rr_mux_8to1 #(.DATA_W(1), .NCH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .din   (din),
        .ready (ready),
        .D     (D),
        .S     (S),
        .valid (valid),
        .grant (grant),
        .busy  (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a pending word is taken only when the output slot is free or being
    // accepted; the winner is the first requester counting upward (mod 8) from the
    // channel after the one last served.
    bit       m_valid = 1'b0;
    bit       m_D     = 1'b0;
    int       m_S     = 0;
    int       m_ptr   = 0;
    bit [7:0] m_grant = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_D     = 1'b0;
            m_S     = 0;
            m_ptr   = 0;
            m_grant = 8'h00;
        end else begin
            m_grant = 8'h00;
            if (!m_valid || ready) begin
                if (req != 8'h00) begin
                    int w;
                    w = -1;
                    for (int k = 0; k < 8; k++)
                        if (w < 0 && req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
                    m_D        = din[w];
                    m_S        = w;
                    m_valid    = 1'b1;
                    m_ptr      = (w + 1) % 8;
                    m_grant[w] = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_valid", valid, m_valid);
            chk("model_D", D, m_D);
            chk("model_S", S, m_S);
            chk("model_grant", grant, m_grant);
            chk("model_busy", busy, m_valid | (|req));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    bit [7:0] src_req;
    bit [7:0] src_din;
    bit       w;
    logic [7:0] y;

    initial begin
        rst   = 1'b1;
        req   = 8'h00;
        din   = 8'h00;
        ready = 1'b0;
        #12;
        chk("rst_valid", valid, 0);
        chk("rst_D", D, 0);
        chk("rst_S", S, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        step();
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Async reset in the middle of a stream, then a single word from ch2.
        req = 8'hFF; din = 8'h55; ready = 1'b1;
        step(); step(); step();
        rst = 1'b1;
        #1;
        chk("midrst_valid", valid, 0);
        chk("midrst_D", D, 0);
        chk("midrst_S", S, 0);
        chk("midrst_grant", grant, 0);
        step();
        rst = 1'b0; req = 8'h04; din = 8'h04; ready = 1'b0;
        step();
        chk("post_rst_valid", valid, 1);
        chk("post_rst_S", S, 2);
        chk("post_rst_D", D, 1);
        chk("post_rst_grant", grant, 8'h04);
        req = 8'h00;
        step();
        chk("post_rst_grant_once", grant, 8'h00);
        chk("post_rst_hold", valid, 1);
        ready = 1'b1;
        step();
        chk("post_rst_drain", valid, 0);

        // Wrap-around with all requests held.
        pulse_rst();
        req = 8'hFF; din = 8'h55; ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("wrap_S", S, i % 8);
            chk("wrap_D", D, (i % 2 == 0) ? 1 : 0);
            chk("wrap_valid", valid, 1);
            chk("wrap_grant", grant, 32'(8'h01 << (i % 8)));
        end
        req = 8'h00;
        step();
        chk("wrap_idle", valid, 0);

        // Backpressure on a single word from ch5.
        pulse_rst();
        req = 8'h20; din = 8'h20; ready = 1'b0;
        step();
        chk("bp_grant", grant, 8'h20);
        req = 8'h00; din = 8'h00;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_D", D, 1);
            chk("bp_S", S, 5);
            chk("bp_valid", valid, 1);
            chk("bp_grant_zero", grant, 0);
        end
        ready = 1'b1;
        step();
        chk("bp_release_valid", valid, 0);
        chk("bp_keep_S", S, 5);
        chk("bp_keep_D", D, 1);

        // Fairness: ch1 held, ch6 pulsed once with ptr=2.
        pulse_rst();
        ready = 1'b1; din = 8'h00;
        req = 8'h02;
        step();
        chk("fair_S0", S, 1);
        req = 8'h42;
        step();
        chk("fair_S1", S, 6);
        chk("fair_g1", grant, 8'h40);
        req = 8'h02;
        step();
        chk("fair_S2", S, 1);
        step();
        chk("fair_S3", S, 1);
        req = 8'h00;
        step();

        // Accept and reload on the same edge.
        pulse_rst();
        req = 8'h08; din = 8'h08; ready = 1'b0;
        step();
        chk("b2b_S3", S, 3);
        req = 8'h01; din = 8'h01; ready = 1'b1;
        step();
        chk("b2b_S0", S, 0);
        chk("b2b_valid", valid, 1);
        chk("b2b_D", D, 1);
        req = 8'h00;
        step();
        chk("b2b_idle", valid, 0);

        // Loop-back through a 1:8 demux of D at index S.
        pulse_rst();
        ready = 1'b1;
        for (int ch = 0; ch < 8; ch++) begin
            w   = 1'($urandom_range(0, 1));
            req = 8'h01 << ch;
            din = {7'd0, w} << ch;
            step();
            y = 8'h00;
            y[S] = D;
            chk("loop_Y", y, 32'({7'd0, w} << ch));
            chk("loop_S", S, ch);
        end
        req = 8'h00;
        step();

        // Randomized sources with a mid-run async reset.
        pulse_rst();
        src_req = 8'h00;
        src_din = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 8; i++) begin
                if (m_grant[i]) begin
                    if ($urandom_range(0, 1) == 0) src_req[i] = 1'b0;
                    else src_din[i] = 1'($urandom_range(0, 1));
                end else if (!src_req[i] && $urandom_range(0, 3) == 0) begin
                    src_req[i] = 1'b1;
                    src_din[i] = 1'($urandom_range(0, 1));
                end
            end
            req   = src_req;
            din   = src_din;
            ready = ($urandom_range(0, 9) < 7);
            if (cyc == 1500) pulse_rst();
            step();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_8to1.md
Name: rr_mux_8to1

Overview:
- Sequential 8:1 round-robin multiplexer: the collecting end of the 1:8 demux path.
- Arbitrates among 8 requesting source channels and captures one channel's word into an output register.
- Presents the word as D with its channel index as S, so a downstream demux_1to8 can route D back to output Y[S].
- Valid/ready handshake toward the consumer; one-cycle grant pulse back to each source.

Parameters:
- DATA_W, 1: width of each channel word and of D (1 matches the 1-bit demux data path).
- NCH, 8: number of channels, fixed at 8 (S is 3 bits); other values are not supported.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  per-channel request; req[i]=1 means din[i] holds a word to send.
- din  input  8*DATA_W  channel words, packed; channel i at bits [i*DATA_W +: DATA_W].
- ready  input  1  consumer accepts D/S this cycle when valid=1.
- D  output  DATA_W  registered selected word.
- S  output  3  registered index of the channel that supplied D.
- valid  output  1  D/S hold a word not yet accepted.
- grant  output  8  one-hot, one-cycle pulse on the cycle channel i's word is captured.
- busy  output  1  valid, or any req bit set.

Behaviour:
- Reset (async, active-high, effective immediately):
  - D=0, S=0, valid=0, grant=0.
  - Priority pointer ptr=0; state=IDLE.
  - Any held word is discarded; no grant is issued for it.
- busy is combinational: valid | (|req).
- States: IDLE (valid=0) and HOLD (valid=1).
- Load condition: (state==IDLE) or (state==HOLD and ready==1).
- Selection when the load condition holds and req!=0:
  - sel = first i in scan order ptr, ptr+1, ..., 7, 0, ..., ptr-1 with req[i]=1 (mod-8 wrap).
  - At the clock edge: D<=din[sel], S<=sel, valid<=1, ptr<=(sel+1) mod 8, state<=HOLD.
  - grant: registered, equal to onehot(sel) for exactly the one cycle after that edge, otherwise 0.
- Latency: req rising in IDLE -> valid=1 and grant pulse one clock later.
- HOLD with ready=0: D, S, valid held stable, ptr unchanged, grant=0.
  - Req changes in HOLD are ignored until a load occurs.
- HOLD with ready=1:
  - If req!=0: next word loads on the same edge; valid stays 1 (back-to-back, one transfer per clock).
  - If req==0: valid<=0, state<=IDLE; D and S keep their last values.
- ready in IDLE is ignored.
- Source rules:
  - Sources keep din[i] stable while req[i]=1.
  - On seeing grant[i], a source must drop req[i] or present its next word in the same cycle.
  - The block samples req again only on the next load edge.
  - A channel holding req high continuously is served again only after every other requesting channel; this guarantees fairness.
- Wrap-around: after serving channel 7, ptr=0.
  - With all 8 requests held, S sequence is 0,1,...,7,0,...
- Reset asserted mid-transfer (valid=1): valid falls asynchronously; after release, the block is in IDLE with ptr=0.
- Transfer count: one word per cycle in which valid & ready; no word is ever duplicated or dropped outside reset.

Test Plan:
- Reset: assert rst with req=8'hFF mid-stream -> immediately valid=0, D=0, S=0, grant=0; after release with req=8'h04, din[2]=1 -> next clock valid=1, S=2, D=1, grant=8'h04 for one cycle.
- Round-robin wrap: req=8'hFF held, ready=1 continuously, din alternating 1/0 by channel -> S=0,1,...,7,0 on consecutive cycles, valid stays 1, grant walks 8'h01..8'h80.
- Backpressure: single word from ch5 (D=1), ready=0 for 4 cycles -> D=1, S=5, valid=1 stable, grant pulses once only; ready=1 with req=0 -> valid=0 next cycle.
- Fairness: req[1] held high, req[6] pulsed once at ptr=2 -> order of S is 1,6,1,1; ch1 is never served twice while ch6 is pending.
- Simultaneous accept and load: HOLD with S=3, ready=1, req=8'h01 -> next cycle S=0, valid remains 1, no idle bubble.
- Loop-back with demux_1to8: connect D/S into the demux, drive single-channel words in turn -> Y[S]=D for each accepted transfer and all other Y bits 0.
